turn_lever_conditioner: RTL and testbench

- Front-end for the tail-light sequencer. Conditions the raw steering-column lever and hazard switch inputs.
- Synchronizes and debounces them, then arbitrates them into clean, mutually consistent left/right turn requests.
- Aligns request changes to a blink-rate step tick, so the downstream light sequencer only ever sees request changes on step boundaries.

---
 rtl/turn_lever_conditioner.sv | 173 +++++++++++++++++
 tb/tb_turn_lever_conditioner.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/turn_lever_conditioner.sv
// Lever/hazard front-end: synchronize, debounce, arbitrate and align turn requests to step ticks.
// Optional hazard path enabled by defining TURN_HAZARD_EN.
module turn_lever_conditioner #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned TICK_DIV        = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic lever_left_raw,
  input  logic lever_right_raw,
  input  logic hazard_raw,
  output logic left,
  output logic right,
  output logic step,
  output logic active
);

`ifdef TURN_HAZARD_EN
  localparam int unsigned NumIn = 3;
`else
  localparam int unsigned NumIn = 2;
`endif

  localparam int unsigned CntW  = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0]  CntMax  = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TickW-1:0] TickMax = TickW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLeft,
    StRight,
    StHazard,
    StClear
  } state_e;

  logic [NumIn-1:0] raw;
  logic [NumIn-1:0] deb;
  logic             dl, dr, dh;

`ifdef TURN_HAZARD_EN
  assign raw = {hazard_raw, lever_right_raw, lever_left_raw};
  assign dh  = deb[2];
`else
  logic unused_hazard;
  assign unused_hazard = hazard_raw;
  assign raw = {lever_right_raw, lever_left_raw};
  assign dh  = 1'b0;
`endif

  assign dl = deb[0];
  assign dr = deb[1];

  // One synchronizer + debouncer per conditioned input.
  for (genvar g = 0; g < NumIn; g++) begin : g_in
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   deb_q, deb_d;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], raw[g]};
      end
    end

    always_comb begin
      cnt_d = cnt_q;
      deb_d = deb_q;
      if (synced == deb_q) begin
        cnt_d = '0;
      end else if (cnt_q == CntMax) begin
        deb_d = ~deb_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_q <= '0;
        deb_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        deb_q <= deb_d;
      end
    end

    assign deb[g] = deb_q;
  end

  // Arbiter
  state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (dh) begin
      state_d = StHazard;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (dl && !dr) begin
            state_d = StLeft;
          end else if (dr && !dl) begin
            state_d = StRight;
          end
        end
        StLeft:   if (!dl || dr) state_d = StClear;
        StRight:  if (!dr || dl) state_d = StClear;
        StHazard: state_d = StClear;
        // A lever must be released before a new direction is taken.
        StClear:  if (!dl && !dr) state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  logic req_l, req_r;
  assign req_l  = (state_q == StLeft)  || (state_q == StHazard);
  assign req_r  = (state_q == StRight) || (state_q == StHazard);
  assign active = (state_q != StIdle);

  // Step tick: step_q is high while the counter sits at TICK_DIV-1.
  logic [TickW-1:0] tick_q, tick_d;
  logic             step_q, step_d;

  always_comb begin
    tick_d = (tick_q == TickMax) ? '0 : tick_q + TickW'(1);
    step_d = (tick_d == TickMax);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_q <= '0;
      step_q <= 1'b0;
    end else begin
      tick_q <= tick_d;
      step_q <= step_d;
    end
  end

  // Requests reach the sequencer only on the edge that ends a step cycle.
  logic left_q, right_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      left_q  <= 1'b0;
      right_q <= 1'b0;
    end else if (step_q) begin
      left_q  <= req_l;
      right_q <= req_r;
    end
  end

  assign left  = left_q;
  assign right = right_q;
  assign step  = step_q;

endmodule

// File: tb/tb_turn_lever_conditioner.sv
// Self-checking bench: random lever/hazard stimulus against a behavioural model, plus directed literals.
module tb_turn_lever_conditioner;
  localparam int Sync = 2;
  localparam int Deb  = 4;
  localparam int Tdiv = 8;
`ifdef TURN_HAZARD_EN
  localparam bit HazEn = 1'b1;
`else
  localparam bit HazEn = 1'b0;
`endif

  localparam int MIdle = 0, MLeft = 1, MRight = 2, MHaz = 3, MClear = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ll = 1'b0, lr = 1'b0, hz = 1'b0;
  logic left, right, step, active;

  int checks = 0;
  int errors = 0;

  turn_lever_conditioner #(
    .SYNC_STAGES    (Sync),
    .DEBOUNCE_CYCLES(Deb),
    .TICK_DIV       (Tdiv)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .lever_left_raw (ll),
    .lever_right_raw(lr),
    .hazard_raw     (hz),
    .left           (left),
    .right          (right),
    .step           (step),
    .active         (active)
  );

  always #5 clk = ~clk;

  // Behavioural model
  bit [2:0] raw_hist[$];
  bit [2:0] sync_hist[$];
  bit [2:0] m_deb;
  int       m_mode;
  int       m_e;
  bit       m_step, m_left, m_right;

  function automatic void model_reset();
    raw_hist.delete();
    sync_hist.delete();
    m_deb   = '0;
    m_mode  = MIdle;
    m_e     = 0;
    m_step  = 1'b0;
    m_left  = 1'b0;
    m_right = 1'b0;
  endfunction

  function automatic void model_edge(input bit [2:0] r);
    bit [2:0] s, deb_n;
    bit       dl, dr, dh, all_diff;
    int       mode_n;
    s = (raw_hist.size() >= Sync) ? raw_hist[raw_hist.size() - Sync] : 3'b000;
    raw_hist.push_back(r);
    if (raw_hist.size() > 8) void'(raw_hist.pop_front());
    sync_hist.push_back(s);
    if (sync_hist.size() > 8) void'(sync_hist.pop_front());
    // A debounced bit flips once the last Deb synchronized samples all disagree with it.
    deb_n = m_deb;
    if (sync_hist.size() >= Deb) begin
      for (int i = 0; i < 3; i++) begin
        all_diff = 1'b1;
        for (int k = 0; k < Deb; k++)
          if (sync_hist[sync_hist.size() - 1 - k][i] == m_deb[i]) all_diff = 1'b0;
        if (all_diff) deb_n[i] = ~m_deb[i];
      end
    end
    if (!HazEn) deb_n[2] = 1'b0;
    dl = m_deb[0];
    dr = m_deb[1];
    dh = m_deb[2];
    mode_n = m_mode;
    if (dh) mode_n = MHaz;
    else if (m_mode == MIdle) begin
      if (dl && !dr) mode_n = MLeft;
      else if (dr && !dl) mode_n = MRight;
    end else if (m_mode == MLeft) begin
      if (!dl || dr) mode_n = MClear;
    end else if (m_mode == MRight) begin
      if (!dr || dl) mode_n = MClear;
    end else if (m_mode == MHaz) mode_n = MClear;
    else if (!dl && !dr) mode_n = MIdle;
    if (m_step) begin
      m_left  = (m_mode == MLeft)  || (m_mode == MHaz);
      m_right = (m_mode == MRight) || (m_mode == MHaz);
    end
    m_e++;
    m_step = (m_e % Tdiv) == (Tdiv - 1);
    m_mode = mode_n;
    m_deb  = deb_n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    check("left", {31'b0, left}, {31'b0, m_left});
    check("right", {31'b0, right}, {31'b0, m_right});
    check("step", {31'b0, step}, {31'b0, m_step});
    check("active", {31'b0, active}, {31'b0, (m_mode != MIdle)});
  endtask

  // One clock: model advances on the edge, outputs compared on the falling edge.
  task automatic cycle();
    @(posedge clk);
    if (!reset) model_reset();
    else model_edge({hz, lr, ll});
    @(negedge clk);
    compare();
  endtask

  // Called on a falling edge; asserts reset mid-cycle and checks it acts without a clock edge.
  task automatic async_reset(input string tag);
    #2 reset = 1'b0;
    #1;
    check({tag, "_left"}, {31'b0, left}, 32'd0);
    check({tag, "_right"}, {31'b0, right}, 32'd0);
    check({tag, "_step"}, {31'b0, step}, 32'd0);
    check({tag, "_active"}, {31'b0, active}, 32'd0);
    ll = 1'b0;
    lr = 1'b0;
    hz = 1'b0;
    repeat (3) cycle();
    reset = 1'b1;
  endtask

  initial begin
    int steps, n;
    bit act_seen, right_seen;
    int dur;
    model_reset();
    repeat (3) cycle();
    reset = 1'b1;

    // Idle: step pulses at edges 7,15,23,31,39 after release.
    steps = 0;
    act_seen = 1'b0;
    repeat (40) begin
      cycle();
      steps += int'(step);
      act_seen |= active;
    end
    check("idle_steps", steps, 5);
    check("idle_active", {31'b0, act_seen}, 32'd0);

    // Left held: 2 sync + 4 debounce + 1 arbiter edges; left loads at edge 48.
    ll = 1'b1;
    n = 0;
    while (!active && n < 20) begin
      cycle();
      n++;
    end
    check("left_active_latency", n, 7);
    while (!left && n < 40) begin
      cycle();
      n++;
    end
    check("left_out_latency", n, 8);
    check("left_right_quiet", {31'b0, right}, 32'd0);

    async_reset("async");

    // Short right-lever glitches never pass the debouncer.
    act_seen = 1'b0;
    right_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      lr = ((i % 4) < 2);
      cycle();
      act_seen |= active;
      right_seen |= right;
    end
    lr = 1'b0;
    repeat (20) begin
      cycle();
      act_seen |= active;
      right_seen |= right;
    end
    check("glitch_active", {31'b0, act_seen}, 32'd0);
    check("glitch_right", {31'b0, right_seen}, 32'd0);

    // Randomized segments: holds and glitches, occasional async reset.
    repeat (250) begin
      if ($urandom_range(0, 39) == 0) begin
        async_reset("rand_async");
      end else begin
        ll = 1'($urandom_range(0, 1));
        lr = 1'($urandom_range(0, 1));
        hz = ($urandom_range(0, 3) == 0);
        dur = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 30);
        repeat (dur) cycle();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
